// File: rtl/lsu_subword.sv
// Load/store unit between the CPU MEM stage and a word-only data memory.
// Byte and halfword stores are done as read-modify-write of the containing
// word. Loads select the addressed lane and sign- or zero-extend it.
// Misaligned accesses and the illegal size code finish at once with cpu_err
// and never touch memory.
//
// Handshake: a request is taken on a rising edge where cpu_req=1 and
// cpu_ready=1. cpu_ready is high only in IDLE. Requests seen while
// cpu_ready=0 are dropped, not queued. Every accepted request ends with a
// single-cycle cpu_done pulse. cpu_err pulses with cpu_done on an error, and
// cpu_rdata holds the load result while cpu_done is high.
module lsu_subword #(
  parameter int BIG_ENDIAN = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic [1:0]  dbg_state
);

  localparam logic BE = (BIG_ENDIAN != 0);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  offset_q;   // byte offset within the word
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic [15:0] wdata_q;    // only the low half is ever merged into memory

  logic        req_bad;
  logic [1:0]  byte_lane;
  logic        half_hi;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_value;
  logic [31:0] merge_word;

  assign dbg_state = state;

  // Alignment / legality of the incoming request.
  always_comb begin
    req_bad = 1'b0;
    case (cpu_size)
      SZ_BYTE: req_bad = 1'b0;
      SZ_HALF: req_bad = cpu_addr[0];
      SZ_WORD: req_bad = (cpu_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  end

  // Big-endian mirrors the byte lane (3 - offset) and swaps the halves.
  assign byte_lane = BE ? ~offset_q : offset_q;
  assign half_hi   = offset_q[1] ^ BE;

  // Lane selection and extension of the word read back from memory.
  always_comb begin
    sel_byte = mem_data_out[7:0];
    case (byte_lane)
      2'd0: sel_byte = mem_data_out[7:0];
      2'd1: sel_byte = mem_data_out[15:8];
      2'd2: sel_byte = mem_data_out[23:16];
      default: sel_byte = mem_data_out[31:24];
    endcase
    sel_half = half_hi ? mem_data_out[31:16] : mem_data_out[15:0];
    load_value = mem_data_out;
    case (size_q)
      SZ_BYTE: load_value = {{24{~uns_q & sel_byte[7]}}, sel_byte};
      SZ_HALF: load_value = {{16{~uns_q & sel_half[15]}}, sel_half};
      default: load_value = mem_data_out;
    endcase
  end

  // Replace only the target lane(s) of the word read back from memory.
  always_comb begin
    merge_word = mem_data_out;
    if (size_q == SZ_BYTE) begin
      case (byte_lane)
        2'd0: merge_word[7:0]   = wdata_q[7:0];
        2'd1: merge_word[15:8]  = wdata_q[7:0];
        2'd2: merge_word[23:16] = wdata_q[7:0];
        default: merge_word[31:24] = wdata_q[7:0];
      endcase
    end else if (half_hi) begin
      merge_word[31:16] = wdata_q;
    end else begin
      merge_word[15:0] = wdata_q;
    end
  end

  // Control FSM with all CPU- and memory-facing outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      offset_q    <= 2'b00;
      size_q      <= 2'b00;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      wdata_q     <= 16'h0;
      cpu_ready   <= 1'b1;
      cpu_done    <= 1'b0;
      cpu_err     <= 1'b0;
      cpu_rdata   <= 32'h0;
      mem_write   <= 1'b0;
      mem_address <= 32'h0;
      mem_data_in <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            offset_q  <= cpu_addr[1:0];
            size_q    <= cpu_size;
            we_q      <= cpu_we;
            uns_q     <= cpu_unsigned;
            wdata_q   <= cpu_wdata[15:0];
            cpu_ready <= 1'b0;
            cpu_rdata <= 32'h0;
            if (req_bad) begin
              cpu_done <= 1'b1;
              cpu_err  <= 1'b1;
              state    <= S_DONE;
            end else begin
              mem_address <= {cpu_addr[31:2], 2'b00};
              if (cpu_we && (cpu_size == SZ_WORD)) begin
                // Full word: no need to read the old contents.
                mem_write   <= 1'b1;
                mem_data_in <= cpu_wdata;
                state       <= S_WR;
              end else begin
                state <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          if (we_q) begin
            mem_data_in <= merge_word;
            mem_write   <= 1'b1;
            state       <= S_WR;
          end else begin
            cpu_rdata <= load_value;
            cpu_done  <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_WR: begin
          mem_write <= 1'b0;
          cpu_done  <= 1'b1;
          state     <= S_DONE;
        end
        default: begin
          cpu_done  <= 1'b0;
          cpu_err   <= 1'b0;
          cpu_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_subword.sv
// Bench for lsu_subword: instance 0 is little-endian, instance 1 big-endian,
// each with its own word memory. A byte-level reference model predicts load
// results, errors and memory contents.
module tb_lsu_subword;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req [2];
  logic        we [2];
  logic [1:0]  size [2];
  logic        uns [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic        done [2];
  logic [31:0] rdata [2];
  logic        err [2];
  logic [31:0] mem_address [2];
  logic        mem_write [2];
  logic [31:0] mem_data_in [2];
  logic [31:0] mem_data_out [2];
  logic [1:0]  dbg_state [2];

  logic [31:0] dm [2][1024];
  logic [31:0] ref_mem [2][1024];
  logic        fill_en = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q [$];

  // Clock/reset
  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lsu_subword #(.BIG_ENDIAN(g)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(req[g]), .cpu_we(we[g]), .cpu_size(size[g]),
      .cpu_unsigned(uns[g]), .cpu_addr(addr[g]), .cpu_wdata(wdata[g]),
      .cpu_ready(ready[g]), .cpu_done(done[g]), .cpu_rdata(rdata[g]),
      .cpu_err(err[g]), .mem_address(mem_address[g]), .mem_write(mem_write[g]),
      .mem_data_in(mem_data_in[g]), .mem_data_out(mem_data_out[g]),
      .dbg_state(dbg_state[g])
    );
    assign mem_data_out[g] = dm[g][mem_address[g][11:2]];
    always @(posedge clock) begin
      if (fill_en) begin
        for (int i = 0; i < 1024; i++) dm[g][i] <= ref_mem[g][i];
      end else if (mem_write[g]) begin
        dm[g][mem_address[g][11:2]] <= mem_data_in[g];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed view of each word.
  function automatic void ref_access(input int u, input logic w, input logic [1:0] sz,
                                     input logic un, input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er);
    logic [63:0] word, mask, v;
    int off, nb, sh, widx;
    off = int'(a[1:0]);
    widx = int'(a[11:2]);
    rd = 32'h0;
    er = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
    if (er) return;
    nb = 1 << sz;
    sh = (u == 1) ? 8 * (4 - nb - off) : 8 * off;
    mask = (64'd1 << (8 * nb)) - 64'd1;
    word = {32'h0, ref_mem[u][widx]};
    if (!w) begin
      v = (word >> sh) & mask;
      if (!un && nb < 4 && v >= ((mask + 64'd1) >> 1)) v = v | ~mask;
      rd = v[31:0];
    end else begin
      v = (word & ~(mask << sh)) | (({32'h0, wd} & mask) << sh);
      ref_mem[u][widx] = v[31:0];
    end
  endfunction

  // Driver: one request, measure latency and write cycles.
  task automatic do_op(input int u, input logic w, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat, output int wr_cnt);
    int k;
    rd = 32'h0; er = 1'b0; lat = -1; wr_cnt = 0;
    @(negedge clock);
    for (k = 0; k < 20 && !ready[u]; k++) @(negedge clock);
    if (!ready[u]) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    req[u] = 1'b1; we[u] = w; size[u] = sz; uns[u] = un; addr[u] = a; wdata[u] = wd;
    @(posedge clock);
    #1 req[u] = 1'b0;
    for (k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (mem_write[u]) wr_cnt++;
      if (done[u]) begin
        lat = k; rd = rdata[u]; er = err[u];
        break;
      end
    end
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input int u, input logic w, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd, exp_rd;
    logic er, exp_er;
    int lat, wr_cnt, exp_lat;
    string t;
    t = $sformatf("u%0d_%s_sz%0d_a%0h", u, w ? "st" : "ld", sz, a);
    ref_access(u, w, sz, un, a, wd, exp_rd, exp_er);
    do_op(u, w, sz, un, a, wd, rd, er, lat, wr_cnt);
    exp_lat = exp_er ? 1 : (!w || sz == 2'd2) ? 2 : 3;
    check({t, "_err"}, {31'h0, er}, {31'h0, exp_er});
    check({t, "_lat"}, lat, exp_lat);
    check({t, "_wr"}, wr_cnt, (w && !exp_er) ? 1 : 0);
    if (!w) check({t, "_rdata"}, rd, exp_rd);
    @(negedge clock);
    check({t, "_mem"}, dm[u][a[11:2]], ref_mem[u][a[11:2]]);
  endtask

  // Continuous requests; only those present while ready=1 are expected.
  task automatic stream(input int u, input int n);
    logic [31:0] rd;
    logic er;
    logic [33:0] e;
    for (int c = 0; c < n + 10; c++) begin
      @(negedge clock);
      if (done[u]) begin
        if (exp_q.size() == 0) begin
          check("stream_spurious_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("stream_err", {31'h0, err[u]}, {31'h0, e[32]});
          if (!e[33]) check("stream_rdata", rdata[u], e[31:0]);
        end
      end
      if (c < n) begin
        req[u] = 1'b1;
        we[u] = 1'($urandom_range(0, 1));
        size[u] = 2'($urandom_range(0, 3));
        uns[u] = 1'($urandom_range(0, 1));
        addr[u] = 32'($urandom_range(0, 63));
        wdata[u] = $urandom;
        if (ready[u]) begin
          ref_access(u, we[u], size[u], uns[u], addr[u], wdata[u], rd, er);
          exp_q.push_back({we[u], er, rd});
        end
      end else begin
        req[u] = 1'b0;
      end
    end
    check("stream_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int bad;
    for (int u = 0; u < 2; u++) begin
      req[u] = 0; we[u] = 0; size[u] = 0; uns[u] = 0; addr[u] = 0; wdata[u] = 0;
      for (int i = 0; i < 1024; i++) ref_mem[u][i] = $urandom;
    end
    fill_en = 1'b1;
    @(posedge clock);
    #1 fill_en = 1'b0;
    @(negedge clock);
    check("rst_ready", {31'h0, ready[0]}, 32'd1);
    check("rst_done", {31'h0, done[0]}, 32'd0);
    check("rst_err", {31'h0, err[0]}, 32'd0);
    check("rst_rdata", rdata[0], 32'h0);
    check("rst_mem_write", {31'h0, mem_write[0]}, 32'd0);
    check("rst_mem_address", mem_address[0], 32'h0);
    check("rst_mem_data_in", mem_data_in[0], 32'h0);
    reset = 1'b0;

    // Word store/load
    run_op(0, 1, 2'd2, 0, 32'h10, 32'h12345678);
    run_op(0, 0, 2'd2, 0, 32'h10, 32'h0);
    check("lw_0x10_value", dm[0][4], 32'h12345678);
    // Byte RMW
    run_op(0, 1, 2'd2, 0, 32'h20, 32'hAABBCCDD);
    run_op(0, 1, 2'd0, 0, 32'h21, 32'h00000011);
    check("sb_0x21_word", dm[0][8], 32'hAABB11DD);
    run_op(0, 0, 2'd0, 0, 32'h23, 32'h0);
    run_op(0, 0, 2'd0, 1, 32'h23, 32'h0);
    // Halfword
    run_op(0, 1, 2'd2, 0, 32'h30, 32'h0);
    run_op(0, 1, 2'd1, 0, 32'h32, 32'h00008001);
    check("sh_0x32_word", dm[0][12], 32'h80010000);
    run_op(0, 0, 2'd1, 0, 32'h32, 32'h0);
    run_op(0, 0, 2'd1, 1, 32'h32, 32'h0);
    // Misaligned / illegal
    run_op(0, 0, 2'd2, 0, 32'h02, 32'h0);
    run_op(0, 1, 2'd1, 0, 32'h03, 32'hFFFFFFFF);
    run_op(0, 1, 2'd3, 0, 32'h10, 32'hDEADBEEF);
    run_op(0, 1, 2'd2, 0, 32'h11, 32'hDEADBEEF);

    // Reset while the read phase of a byte store is in progress
    @(negedge clock);
    req[0] = 1'b1; we[0] = 1'b1; size[0] = 2'd0; uns[0] = 1'b0;
    addr[0] = 32'h10; wdata[0] = 32'h000000EE;
    @(posedge clock);
    #1 req[0] = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_ready", {31'h0, ready[0]}, 32'd1);
    check("midrst_mem_write", {31'h0, mem_write[0]}, 32'd0);
    check("midrst_mem_address", mem_address[0], 32'h0);
    check("midrst_done", {31'h0, done[0]}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    check("midrst_mem_write2", {31'h0, mem_write[0]}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_word", dm[0][4], ref_mem[0][4]);
    check("midrst_ready_after", {31'h0, ready[0]}, 32'd1);

    // Big-endian byte test
    run_op(1, 1, 2'd2, 0, 32'h20, 32'hAABBCCDD);
    run_op(1, 1, 2'd0, 0, 32'h21, 32'h00000011);
    check("be_sb_0x21_word", dm[1][8], 32'hAA11CCDD);
    run_op(1, 0, 2'd0, 0, 32'h21, 32'h0);
    run_op(1, 0, 2'd1, 0, 32'h22, 32'h0);

    // Randomised individual ops, then continuous-request streams
    for (int i = 0; i < 40; i++)
      run_op(i % 2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
    stream(0, 300);
    stream(1, 300);

    for (int u = 0; u < 2; u++) begin
      bad = 0;
      for (int i = 0; i < 1024; i++) if (dm[u][i] !== ref_mem[u][i]) bad++;
      check($sformatf("final_mem_u%0d", u), bad, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end

endmodule
